// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - SCCB target FSM states, register map constants and reset defaults
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_DATA      = 4'd5,
        ST_DATA_ACK  = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_NA     = 4'd8,
        ST_WAIT_STOP = 4'd9
    } sccb_state_e;

    localparam logic [7:0] COM7_ADDR = 8'h12;
    localparam logic [7:0] PID_ADDR  = 8'h0A;
    localparam logic [7:0] VER_ADDR  = 8'h0B;
    localparam logic [7:0] PID_VAL   = 8'h76;
    localparam logic [7:0] VER_VAL   = 8'h73;

    function automatic logic [7:0] reg_default(input logic [7:0] addr);
        logic [7:0] val;
        case (addr)
            PID_ADDR: val = PID_VAL;
            VER_ADDR: val = VER_VAL;
            default:  val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/sccb_bus_sync.sv
// rtl/sccb_bus_sync.sv - SIOC/SIOD synchronizers with clock-edge and START/STOP pulse detection
module sccb_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sioc_i,
    input  logic siod_i,
    output logic siod_s,
    output logic sioc_rise,
    output logic sioc_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
    logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
    logic                   sioc_prev_q, sioc_prev_d;
    logic                   siod_prev_q, siod_prev_d;
    logic                   sioc_s;

    assign sioc_s = sioc_sync_q[SYNC_STAGES-1];
    assign siod_s = siod_sync_q[SYNC_STAGES-1];

    always_comb begin
        sioc_sync_d = {sioc_sync_q[SYNC_STAGES-2:0], sioc_i};
        siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], siod_i};
        sioc_prev_d = sioc_s;
        siod_prev_d = siod_s;
    end

    // START/STOP need SIOC high both before and after the SIOD edge
    assign sioc_rise = sioc_s & ~sioc_prev_q;
    assign sioc_fall = ~sioc_s & sioc_prev_q;
    assign start_det = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
    assign stop_det  = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;

    // Idle bus is high on both lines, so reset to 1 to avoid false edges
    always_ff @(posedge clk) begin
        if (reset) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
        end else begin
            sioc_sync_q <= sioc_sync_d;
            siod_sync_q <= siod_sync_d;
            sioc_prev_q <= sioc_prev_d;
            siod_prev_q <= siod_prev_d;
        end
    end

endmodule

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB responder with 256x8 register file; SCCB_TARGET_READ_EN adds read support
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       soft_reset,
    output logic       busy,
    input  logic [7:0] cfg_addr,
    output logic [7:0] cfg_data
);

    logic siod_s, sioc_rise, sioc_fall, start_det, stop_det;

    sccb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sioc_i    (sioc_i),
        .siod_i    (siod_i),
        .siod_s    (siod_s),
        .sioc_rise (sioc_rise),
        .sioc_fall (sioc_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    sccb_state_e state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  sub_q, sub_d;
    logic        oe_q, oe_d;
    logic        wr_valid_q, wr_valid_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        soft_reset_q, soft_reset_d;
    logic [7:0]  cfg_data_q, cfg_data_d;
    logic [7:0]  regs_q [256];
    logic [7:0]  regs_d [256];
    logic [7:0]  rx_byte;
`ifdef SCCB_TARGET_READ_EN
    logic        rd_q, rd_d;
    logic [7:0]  rd_byte;
    assign rd_byte = regs_q[sub_q];
`endif

    assign rx_byte = {shift_q, siod_s};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sub_d        = sub_q;
        oe_d         = oe_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        soft_reset_d = 1'b0;
        cfg_data_d   = regs_q[cfg_addr];
        regs_d       = regs_q;
`ifdef SCCB_TARGET_READ_EN
        rd_d         = rd_q;
`endif

        // COM7 reset is applied the cycle after the write that requested it
        if (soft_reset_q) begin
            for (int i = 0; i < 256; i++) regs_d[i] = reg_default(8'(i));
        end

        if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ID;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
`ifdef SCCB_TARGET_READ_EN
            rd_d      = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ID, ST_SUB, ST_DATA: begin
                    if (sioc_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_ID) begin
                                if (rx_byte == DEV_ID) begin
                                    state_d = ST_ID_ACK;
`ifdef SCCB_TARGET_READ_EN
                                end else if (rx_byte == (DEV_ID | 8'h01)) begin
                                    state_d = ST_ID_ACK;
                                    rd_d    = 1'b1;
`endif
                                end else begin
                                    state_d = ST_WAIT_STOP;
                                end
                            end else if (state_q == ST_SUB) begin
                                state_d = ST_SUB_ACK;
                                sub_d   = rx_byte;
                            end else begin
                                state_d = ST_DATA_ACK;
                                sub_d   = sub_q + 8'd1;
                                if (sub_q != PID_ADDR && sub_q != VER_ADDR) begin
                                    regs_d[sub_q] = rx_byte;
                                    wr_valid_d    = 1'b1;
                                    wr_addr_d     = sub_q;
                                    wr_data_d     = rx_byte;
                                    soft_reset_d  = (sub_q == COM7_ADDR) && rx_byte[7];
                                end
                            end
                        end
                    end
                end
                // First falling edge grabs SIOD, the second releases it
                ST_ID_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
                    if (sioc_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d = 1'b0;
                            if (state_q == ST_ID_ACK) begin
                                state_d = ST_SUB;
`ifdef SCCB_TARGET_READ_EN
                                if (rd_q) begin
                                    state_d   = ST_RD_DATA;
                                    oe_d      = ~rd_byte[7];
                                    bit_cnt_d = 4'd1;
                                end
`endif
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                    end
                end
`ifdef SCCB_TARGET_READ_EN
                ST_RD_DATA: begin
                    if (sioc_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = ST_RD_NA;
                        end else begin
                            oe_d      = ~rd_byte[3'd7 - bit_cnt_q[2:0]];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_NA: begin
                    if (sioc_rise) begin
                        if (siod_s) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            sub_d     = sub_q + 8'd1;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RD_DATA;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 7'd0;
            sub_q        <= 8'd0;
            oe_q         <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            soft_reset_q <= 1'b0;
            cfg_data_q   <= 8'd0;
            for (int i = 0; i < 256; i++) regs_q[i] <= reg_default(8'(i));
`ifdef SCCB_TARGET_READ_EN
            rd_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sub_q        <= sub_d;
            oe_q         <= oe_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            soft_reset_q <= soft_reset_d;
            cfg_data_q   <= cfg_data_d;
            regs_q       <= regs_d;
`ifdef SCCB_TARGET_READ_EN
            rd_q         <= rd_d;
`endif
        end
    end

    assign siod_oe    = oe_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign soft_reset = soft_reset_q;
    assign busy       = (state_q != ST_IDLE);
    assign cfg_data   = cfg_data_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - directed self-checking bench for sccb_target acting as an SCCB initiator
module tb_sccb_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sioc_m;
    logic       sda_m;
    logic       siod_i;
    logic       siod_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       soft_reset;
    logic       busy;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] log_addr [$];
    logic [7:0] log_data [$];
    int soft_cnt = 0;
    int soft_orphan = 0;
    int oe_cycles = 0;

    always #5 clk = ~clk;

    assign siod_i = sda_m & ~siod_oe;

    sccb_target dut (
        .clk        (clk),
        .reset      (reset),
        .sioc_i     (sioc_m),
        .siod_i     (siod_i),
        .siod_oe    (siod_oe),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .soft_reset (soft_reset),
        .busy       (busy),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data)
    );

    always @(negedge clk) begin
        if (wr_valid) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (soft_reset) begin
            soft_cnt++;
            if (!wr_valid) soft_orphan++;
        end
        if (siod_oe) oe_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; sioc_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        sioc_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        sioc_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; tick(Q);
        sioc_m = 1'b1; tick(2 * Q);
        sioc_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(Q);
        sioc_m = 1'b1; tick(Q);
        acked = siod_oe;
        tick(Q);
        sioc_m = 1'b0; tick(Q);
    endtask

    task automatic read_byte(output logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            sioc_m = 1'b1; tick(Q);
            v[i] = siod_i;
            tick(Q);
            sioc_m = 1'b0; tick(Q);
        end
    endtask

    task automatic do_write(input logic [7:0] sub, input logic [7:0] data, output logic all_acked);
        logic a0, a1, a2;
        bus_start();
        send_byte(8'h42, a0);
        send_byte(sub, a1);
        send_byte(data, a2);
        bus_stop();
        all_acked = a0 & a1 & a2;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [7:0] v);
        cfg_addr = a;
        tick(2);
        v = cfg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1; sioc_m = 1'b1; sda_m = 1'b1; cfg_addr = 8'h0A;
        tick(4);
        tests_run++; if (siod_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe got %b want 0", siod_oe); end
        tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        tests_run++; if (wr_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        tests_run++; if (wr_data !== 8'h00) begin tests_failed++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        tests_run++; if (soft_reset !== 1'b0) begin tests_failed++; $display("FAIL reset_soft got %b want 0", soft_reset); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (cfg_data !== 8'h00) begin tests_failed++; $display("FAIL reset_cfg_data got %h want 00", cfg_data); end
        reset = 1'b0;
        tick(4);
        cfg_read(8'h0A, v);
        tests_run++; if (v !== 8'h76) begin tests_failed++; $display("FAIL reset_pid got %h want 76", v); end
        cfg_read(8'h0B, v);
        tests_run++; if (v !== 8'h73) begin tests_failed++; $display("FAIL reset_ver got %h want 73", v); end
    endtask

    task automatic test_basic_write();
        logic ok, a;
        logic [7:0] v;
        int base;
        base = log_addr.size();
        do_write(8'h12, 8'h00, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL basic_ack1 got %b want 1", ok); end
        bus_start();
        send_byte(8'h42, a);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_mid got %b want 1", busy); end
        send_byte(8'h3A, a);
        send_byte(8'h04, ok);
        bus_stop();
        tick(4);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end got %b want 0", busy); end
        tests_run++; if (log_addr.size() !== base + 2) begin tests_failed++; $display("FAIL basic_count got %0d want %0d", log_addr.size(), base + 2); end
        if (log_addr.size() >= base + 2) begin
            tests_run++; if (log_addr[base] !== 8'h12 || log_data[base] !== 8'h00) begin tests_failed++; $display("FAIL basic_w0 got %h/%h want 12/00", log_addr[base], log_data[base]); end
            tests_run++; if (log_addr[base+1] !== 8'h3A || log_data[base+1] !== 8'h04) begin tests_failed++; $display("FAIL basic_w1 got %h/%h want 3a/04", log_addr[base+1], log_data[base+1]); end
        end
        cfg_read(8'h3A, v);
        tests_run++; if (v !== 8'h04) begin tests_failed++; $display("FAIL basic_cfg3a got %h want 04", v); end
        tests_run++; if (soft_cnt !== 0) begin tests_failed++; $display("FAIL basic_no_soft got %0d want 0", soft_cnt); end
    endtask

    task automatic test_soft_reset();
        logic ok;
        logic [7:0] v;
        int base;
        do_write(8'h3A, 8'h04, ok);
        base = log_addr.size();
        do_write(8'h12, 8'h80, ok);
        tick(4);
        tests_run++; if (soft_cnt !== 1) begin tests_failed++; $display("FAIL soft_count got %0d want 1", soft_cnt); end
        tests_run++; if (soft_orphan !== 0) begin tests_failed++; $display("FAIL soft_with_wr got %0d want 0", soft_orphan); end
        tests_run++; if (log_addr.size() !== base + 1) begin tests_failed++; $display("FAIL soft_wr_count got %0d want %0d", log_addr.size(), base + 1); end
        if (log_addr.size() >= base + 1) begin
            tests_run++; if (log_addr[base] !== 8'h12 || log_data[base] !== 8'h80) begin tests_failed++; $display("FAIL soft_wr got %h/%h want 12/80", log_addr[base], log_data[base]); end
        end
        cfg_read(8'h3A, v);
        tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL soft_cfg3a got %h want 00", v); end
        cfg_read(8'h12, v);
        tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL soft_com7 got %h want 00", v); end
        cfg_read(8'h0A, v);
        tests_run++; if (v !== 8'h76) begin tests_failed++; $display("FAIL soft_pid got %h want 76", v); end
    endtask

    task automatic test_bad_id();
        logic a;
        int base, oe0;
        base = log_addr.size();
        oe0 = oe_cycles;
        bus_start();
        send_byte(8'h60, a);
        tests_run++; if (a !== 1'b0) begin tests_failed++; $display("FAIL badid_ack got %b want 0", a); end
        send_byte(8'h3A, a);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL badid_busy_mid got %b want 1", busy); end
        bus_stop();
        tick(4);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL badid_busy_end got %b want 0", busy); end
        tests_run++; if (oe_cycles !== oe0) begin tests_failed++; $display("FAIL badid_oe got %0d want %0d", oe_cycles, oe0); end
        tests_run++; if (log_addr.size() !== base) begin tests_failed++; $display("FAIL badid_wr got %0d want %0d", log_addr.size(), base); end
    endtask

    task automatic test_wrap();
        logic a;
        logic [7:0] v;
        int base;
        base = log_addr.size();
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'hFF, a);
        send_byte(8'hAA, a);
        send_byte(8'hBB, a);
        bus_stop();
        tick(4);
        tests_run++; if (log_addr.size() !== base + 2) begin tests_failed++; $display("FAIL wrap_count got %0d want %0d", log_addr.size(), base + 2); end
        if (log_addr.size() >= base + 2) begin
            tests_run++; if (log_addr[base] !== 8'hFF || log_data[base] !== 8'hAA) begin tests_failed++; $display("FAIL wrap_w0 got %h/%h want ff/aa", log_addr[base], log_data[base]); end
            tests_run++; if (log_addr[base+1] !== 8'h00 || log_data[base+1] !== 8'hBB) begin tests_failed++; $display("FAIL wrap_w1 got %h/%h want 00/bb", log_addr[base+1], log_data[base+1]); end
        end
        cfg_read(8'hFF, v);
        tests_run++; if (v !== 8'hAA) begin tests_failed++; $display("FAIL wrap_cfgff got %h want aa", v); end
    endtask

    task automatic test_abort();
        logic a, ok;
        logic [7:0] v;
        int base;
        base = log_addr.size();
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'h20, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        tick(4);
        tests_run++; if (log_addr.size() !== base) begin tests_failed++; $display("FAIL abort_stop_wr got %0d want %0d", log_addr.size(), base); end
        tests_run++; if (siod_oe !== 1'b0) begin tests_failed++; $display("FAIL abort_stop_oe got %b want 0", siod_oe); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_stop_busy got %b want 0", busy); end
        bus_start();
        send_byte(8'h42, a);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        reset = 1'b1;
        sioc_m = 1'b1; sda_m = 1'b1;
        tick(6);
        tests_run++; if (siod_oe !== 1'b0) begin tests_failed++; $display("FAIL abort_rst_oe got %b want 0", siod_oe); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_rst_busy got %b want 0", busy); end
        reset = 1'b0;
        tick(4);
        cfg_read(8'hFF, v);
        tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL abort_rst_regs got %h want 00", v); end
        tests_run++; if (log_addr.size() !== base) begin tests_failed++; $display("FAIL abort_rst_wr got %0d want %0d", log_addr.size(), base); end
        do_write(8'h21, 8'h5A, ok);
        tick(4);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL abort_next_ack got %b want 1", ok); end
        tests_run++; if (log_addr.size() !== base + 1) begin tests_failed++; $display("FAIL abort_next_count got %0d want %0d", log_addr.size(), base + 1); end
        if (log_addr.size() >= base + 1) begin
            tests_run++; if (log_addr[base] !== 8'h21 || log_data[base] !== 8'h5A) begin tests_failed++; $display("FAIL abort_next_wr got %h/%h want 21/5a", log_addr[base], log_data[base]); end
        end
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] v;
        int oe0;
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'h0B, a);
        bus_stop();
        oe0 = oe_cycles;
        bus_start();
        send_byte(8'h43, a);
`ifdef SCCB_TARGET_READ_EN
        tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL read_ack got %b want 1", a); end
        read_byte(v);
        tests_run++; if (v !== 8'h73) begin tests_failed++; $display("FAIL read_data got %h want 73", v); end
        send_bit(1'b1);
        tests_run++; if (siod_oe !== 1'b0) begin tests_failed++; $display("FAIL read_na_oe got %b want 0", siod_oe); end
`else
        tests_run++; if (a !== 1'b0) begin tests_failed++; $display("FAIL read_disabled_ack got %b want 0", a); end
        read_byte(v);
        tests_run++; if (oe_cycles !== oe0) begin tests_failed++; $display("FAIL read_disabled_oe got %0d want %0d", oe_cycles, oe0); end
`endif
        bus_stop();
        tick(4);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL read_busy_end got %b want 0", busy); end
    endtask

    initial begin
        reset = 1'b1; sioc_m = 1'b1; sda_m = 1'b1; cfg_addr = 8'h00;
        test_reset();
        test_basic_write();
        test_soft_reset();
        test_bad_id();
        test_wrap();
        test_abort();
        test_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
